// File: rtl/bit_scan_64b_pkg.sv
// Shared types and helpers for the bit_scan_64b set-bit enumerator.
// Optional build macro: BIT_SCAN_MSB_FIRST_EN (descending index order).
package bit_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index width for a mask of the given width; never less than one bit.
  function automatic int idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bit_scan_64b_if.sv
// Index stream from bit_scan_64b to its consumer (valid/ready with last marker).
interface bit_scan_64b_if #(
  parameter int IDX_W = 6
);
  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] data;
  logic             last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/bit_scan_64b_pri_enc.sv
// Combinational priority encoder: index of the first set bit plus an any-set flag.
// Search direction: lowest bit first, or highest bit first when
// BIT_SCAN_MSB_FIRST_EN is defined. Returns index 0 when no bit is set.
module pri_enc #(
  parameter int WIDTH = 64,
  parameter int IDX_W = 6
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan so that the winning bit is the one written last in the loop.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
`ifdef BIT_SCAN_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (data_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/bit_scan_64b.sv
// Iterative set-bit enumerator: loads a mask on init_i and streams the index of
// every set bit, one per accepted beat, then pulses done_o.
// Optional build macro: BIT_SCAN_MSB_FIRST_EN (highest index first).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for init_i; mask_r empty
// SCAN  | emitting indices of the bits still pending in mask_r
// DONE  | one-cycle done_o pulse; init_i ignored here
module bit_scan_64b
  import bit_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter bit OUT_REG    = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  init_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  busy_o,
  output logic                  done_o,
  bit_scan_64b_if.master        out_if
);

  localparam int IDX_W = idx_w(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [DATA_WIDTH-1:0] mask_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  out_vld_r;
  logic                  out_last_r;
  logic [IDX_W-1:0]      out_idx_r;

  logic [IDX_W-1:0]      enc_idx;
  logic                  enc_any;
  logic [DATA_WIDTH-1:0] mask_clr;
  logic                  enc_last;
  logic                  hs;
  logic                  load;

  pri_enc #(
    .WIDTH (DATA_WIDTH),
    .IDX_W (IDX_W)
  ) u_pri_enc (
    .data_i (mask_r),
    .idx_o  (enc_idx),
    .any_o  (enc_any)
  );

  // Mask with the selected bit removed; if nothing else remains it was the last one.
  always_comb begin
    mask_clr = mask_r & ~(ONE << enc_idx);
    enc_last = enc_any && (mask_clr == '0);
  end

  // Handshake and refill decisions. With the output register, mask_r only holds
  // bits not yet moved into the register, so the register refills as it drains.
  always_comb begin
    hs   = 1'b0;
    load = 1'b0;
    if (OUT_REG) begin
      hs   = out_vld_r && out_if.ready;
      load = (state == SCAN) && enc_any && (!out_vld_r || out_if.ready);
    end else begin
      hs   = (state == SCAN) && out_if.ready;
    end
  end

  // Sequencer FSM with mask clearing and the optional output register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      mask_r     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      out_vld_r  <= 1'b0;
      out_last_r <= 1'b0;
      out_idx_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_i) begin
            mask_r <= data_i;
            busy_r <= 1'b1;
            if (data_i == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (OUT_REG) begin
            if (load) begin
              mask_r     <= mask_clr;
              out_vld_r  <= 1'b1;
              out_idx_r  <= enc_idx;
              out_last_r <= enc_last;
            end else if (hs) begin
              out_vld_r  <= 1'b0;
              out_idx_r  <= '0;
              out_last_r <= 1'b0;
            end
            if (hs && out_last_r) begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end else if (hs) begin
            mask_r <= mask_clr;
            if (enc_last) begin
              state  <= DONE;
              done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  // Output mux: registered stage, or index decoded straight from mask_r.
  always_comb begin
    if (OUT_REG) begin
      out_if.valid = out_vld_r;
      out_if.data  = out_idx_r;
      out_if.last  = out_last_r;
    end else begin
      out_if.valid = (state == SCAN);
      out_if.data  = (state == SCAN) ? enc_idx : '0;
      out_if.last  = (state == SCAN) && enc_last;
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;

endmodule
